// File: rtl/bit_stuffer_if.sv
// Handshake bundle between the packet serializer, the bit stuffer and the
// NRZI encoder. The slave modport is the stuffer's view; master is the
// view of whatever drives raw bits in and consumes the stuffed stream.
interface bit_stuffer_if;
  // Upstream (raw bit) side
  logic in_bit;
  logic in_valid;
  logic in_last;
  logic in_ready;
  // Downstream (stuffed bit) side
  logic out_bit;
  logic out_valid;
  logic out_last;
  logic out_stuffed;
  logic out_ready;

  modport master (
    output in_bit,
    output in_valid,
    output in_last,
    input  in_ready,
    input  out_bit,
    input  out_valid,
    input  out_last,
    input  out_stuffed,
    output out_ready
  );

  modport slave (
    input  in_bit,
    input  in_valid,
    input  in_last,
    output in_ready,
    output out_bit,
    output out_valid,
    output out_last,
    output out_stuffed,
    input  out_ready
  );
endinterface

// File: rtl/bit_stuffer.sv
// Transmit-side USB bit stuffer: inserts a 0 after every MAX_ONES
// consecutive 1s of the raw stream. One-entry registered output stage,
// so a bit accepted this cycle is presented downstream on the next.
module bit_stuffer #(
  parameter int unsigned MAX_ONES = 6
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              stuff_en,
  bit_stuffer_if.slave      bus
);

  localparam int unsigned CNT_W = $clog2(MAX_ONES + 1);

  typedef enum logic [0:0] {
    StPass,
    StStuff
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   one_count_q;
  logic               pend_last_q;
  logic               out_bit_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic               out_stuffed_q;

  logic               slot_free;
  logic               in_ready;
  logic               accept;
  logic               run_full;

  // Output slot is free when empty or being drained this cycle
  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    in_ready  = slot_free && (state_q == StPass);
    accept    = bus.in_valid && in_ready;
    // This 1 completes a run of MAX_ONES, so a stuff bit must follow it
    run_full  = stuff_en && bus.in_bit && (one_count_q == CNT_W'(MAX_ONES - 1));
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_bit     = out_bit_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_stuffed = out_stuffed_q;

  // PASS/STUFF state machine with registered output stage and ones counter
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q       <= StPass;
      one_count_q   <= '0;
      pend_last_q   <= 1'b0;
      out_bit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_stuffed_q <= 1'b0;
    end else begin
      unique case (state_q)
        StPass: begin
          if (accept) begin
            out_bit_q     <= bus.in_bit;
            out_valid_q   <= 1'b1;
            out_stuffed_q <= 1'b0;
            if (run_full) begin
              // Packet end (if any) moves onto the stuff bit that follows
              one_count_q <= '0;
              state_q     <= StStuff;
              pend_last_q <= bus.in_last;
              out_last_q  <= 1'b0;
            end else if (bus.in_last) begin
              out_last_q  <= 1'b1;
              one_count_q <= '0;
            end else begin
              out_last_q  <= 1'b0;
              one_count_q <= (stuff_en && bus.in_bit) ? one_count_q + CNT_W'(1) : '0;
            end
          end else if (bus.out_ready) begin
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_stuffed_q <= 1'b0;
          end
        end
        StStuff: begin
          // Input is held off (in_ready low) for the whole stuff cycle
          if (slot_free) begin
            out_bit_q     <= 1'b0;
            out_valid_q   <= 1'b1;
            out_stuffed_q <= 1'b1;
            out_last_q    <= pend_last_q;
            state_q       <= StPass;
          end
        end
      endcase
    end
  end

  // A stalled output must be held until the downstream takes it
  a_out_stable : assert property (
    @(posedge clk) disable iff (!nRST)
    (out_valid_q && !bus.out_ready) |=>
      (out_valid_q && $stable(out_bit_q) && $stable(out_last_q) && $stable(out_stuffed_q))
  );

endmodule

// File: tb/tb_bit_stuffer.sv
// Scoreboard bench for bit_stuffer: a packet-level model pushes the
// expected stuffed stream; a monitor pops on every output handshake.
module tb_bit_stuffer;
  localparam int unsigned MaxOnes = 6;

  logic clk = 1'b0;
  logic nRST;
  logic stuff_en;

  bit_stuffer_if bus_if ();

  bit_stuffer #(
    .MAX_ONES (MaxOnes)
  ) dut (
    .clk      (clk),
    .nRST     (nRST),
    .stuff_en (stuff_en),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  // Expected output entries: {bit, last, stuffed}
  logic [2:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int or_mode = 0;   // 0: ready, 1: random, 2: 1,0,0 pattern, 3: stalled
  int or_phase = 0;
  int ir_low_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Packet-level reference: count the current run of 1s, and whenever it
  // reaches MaxOnes emit an extra 0; the packet end rides on the last item.
  task automatic model_pkt(input logic [31:0] bits, input int len, input bit en);
    int  run;
    bit  b;
    bit  is_last;
    run = 0;
    for (int i = 0; i < len; i++) begin
      b       = bits[i];
      is_last = (i == len - 1);
      run     = (en && b) ? run + 1 : 0;
      if (run == int'(MaxOnes)) begin
        exp_q.push_back({b, 1'b0, 1'b0});
        exp_q.push_back({1'b0, is_last, 1'b1});
        run = 0;
      end else begin
        exp_q.push_back({b, is_last, 1'b0});
      end
    end
  endtask

  // Drive one packet, LSB first; inputs change #1 after posedge
  task automatic send_pkt(input logic [31:0] bits, input int len, input bit en,
                          input int gap_pct, input bit do_model);
    bit accepted;
    int guard;
    stuff_en = en;
    if (do_model) model_pkt(bits, len, en);
    for (int i = 0; i < len; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus_if.in_valid = 1'b0;
        bus_if.in_bit   = 1'($urandom);
        bus_if.in_last  = 1'($urandom);
        @(posedge clk);
        #1;
      end
      bus_if.in_valid = 1'b1;
      bus_if.in_bit   = bits[i];
      bus_if.in_last  = (i == len - 1);
      accepted = 1'b0;
      guard = 0;
      while (!accepted) begin
        @(negedge clk);
        accepted = bus_if.in_ready;
        @(posedge clk);
        #1;
        guard++;
        if (guard > 1000) begin
          $display("FAIL in_ready_timeout: got 0 expected 1");
          $fatal(1);
        end
      end
    end
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Downstream ready generator
  initial begin
    bus_if.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       bus_if.out_ready = 1'b1;
        1:       bus_if.out_ready = 1'($urandom_range(0, 1));
        2: begin
          bus_if.out_ready = (or_phase % 3 == 0);
          or_phase++;
        end
        default: bus_if.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pop/compare on handshake, check stability while stalled
  initial begin
    logic [2:0] prev;
    logic [2:0] cur;
    logic [2:0] exp;
    bit prev_stall;
    prev = '0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      cur = {bus_if.out_bit, bus_if.out_last, bus_if.out_stuffed};
      if (!nRST) begin
        prev_stall = 1'b0;
      end else begin
        if (!bus_if.in_ready) ir_low_cnt++;
        if (prev_stall) check("stall_hold", {bus_if.out_valid, cur}, {1'b1, prev});
        if (bus_if.out_valid && bus_if.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", {1'b1, cur}, 0);
          end else begin
            exp = exp_q.pop_front();
            check("out_bit_last_stuffed", cur, exp);
          end
        end
        prev_stall = bus_if.out_valid && !bus_if.out_ready;
        prev = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] bits;
    int          len;
    bit          en;

    nRST            = 1'b0;
    stuff_en        = 1'b1;
    bus_if.in_bit   = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
    #3;
    check("reset_outputs", {bus_if.out_bit, bus_if.out_valid, bus_if.out_last,
                            bus_if.out_stuffed}, 4'b0000);
    check("reset_in_ready", bus_if.in_ready, 1'b1);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    or_mode = 0;

    // 8 ones: stuff after the 6th, last on the 9th output
    send_pkt(32'hFF, 8, 1'b1, 0, 1'b1);
    drain();

    // 12 ones: two stuff bits, input held off exactly twice
    ir_low_cnt = 0;
    send_pkt(32'hFFF, 12, 1'b1, 0, 1'b1);
    drain();
    check("stall_cycles_12_ones", ir_low_cnt, 2);

    // 5-runs never stuff
    send_pkt(32'b0111_1101_1111, 12, 1'b1, 0, 1'b1);
    drain();

    // Two back-to-back 6-one packets each ending in a last stuff bit
    send_pkt(32'h3F, 6, 1'b1, 0, 1'b1);
    send_pkt(32'h3F, 6, 1'b1, 0, 1'b1);
    drain();

    // Backpressure pattern with the test-1 packet
    or_mode = 2;
    or_phase = 0;
    send_pkt(32'hFF, 8, 1'b1, 0, 1'b1);
    drain();
    or_mode = 0;

    // Transparent mode
    send_pkt(32'h3FF, 10, 1'b0, 0, 1'b1);
    drain();

    // Reset while a stuff bit is pending
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    send_pkt(32'h3F, 6, 1'b1, 0, 1'b0);
    or_mode = 3;
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    check("stuff_pending_in_ready", bus_if.in_ready, 1'b0);
    check("stuff_pending_out_valid", bus_if.out_valid, 1'b1);
    check("pre_reset_queue", exp_q.size(), 0);
    #2;
    nRST = 1'b0;
    #1;
    check("midstuff_reset_outputs", {bus_if.out_bit, bus_if.out_valid, bus_if.out_last,
                                     bus_if.out_stuffed}, 4'b0000);
    check("midstuff_reset_in_ready", bus_if.in_ready, 1'b1);
    @(negedge clk);
    nRST = 1'b1;
    or_mode = 0;
    @(posedge clk);
    #1;
    send_pkt(32'h1F, 5, 1'b1, 0, 1'b1);
    drain();

    // Randomized packets, gaps and backpressure
    or_mode = 1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 32);
      for (int i = 0; i < 32; i++) bits[i] = ($urandom_range(99) < 80);
      en = ($urandom_range(99) < 75);
      send_pkt(bits, len, en, 20, 1'b1);
    end
    drain();
    or_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
